vga_timing_gen: RTL and testbench

//  Generates VGA raster timing for the game and overlay stages. Outputs the pixel

---
 rtl/vga_timing_if.sv | 25 ++
 rtl/vga_timing_gen.sv | 93 +++++++++
 tb/tb_vga_timing_gen.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_if.sv
// Raster timing bundle between the timing generator and its pixel consumers.
// pix_ce flows into the generator; counters, qualifiers, syncs and strobes flow out.
interface vga_timing_if;
    logic       pix_ce;
    logic [9:0] CounterX;
    logic [8:0] CounterY;
    logic       inDisplayArea;
    logic       vga_h_sync;
    logic       vga_v_sync;
    logic       line_start;
    logic       frame_start;
    logic [7:0] frame_count;

    modport master (
        input  pix_ce,
        output CounterX, CounterY, inDisplayArea, vga_h_sync, vga_v_sync,
               line_start, frame_start, frame_count
    );

    modport slave (
        output pix_ce,
        input  CounterX, CounterY, inDisplayArea, vga_h_sync, vga_v_sync,
               line_start, frame_start, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel counters, display qualifier, H/V syncs, line/frame strobes, frame count.
// Latency: every output is registered from the next-state counters, so all outputs describe the same pixel.
// Backpressure: none; pix_ce gates advance, outputs hold and strobes drop while it is low.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 20,
    parameter int SYNC_POL = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    vga_timing_if.master vif
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    if (H_TOTAL > 1024 || V_TOTAL > 512) begin : g_size_err
        $error("vga_timing_gen: H_TOTAL must be <= 1024 and V_TOTAL <= 512");
    end
    if (H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
        V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : g_zero_err
        $error("vga_timing_gen: porch and sync widths must be non-zero");
    end

    localparam logic [9:0] X_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] X_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [8:0] Y_LAST = 9'(V_TOTAL - 1);
    localparam logic [8:0] Y_ACT  = 9'(V_ACTIVE);
    localparam logic [8:0] VS_BEG = 9'(V_ACTIVE + V_FRONT);
    localparam logic [8:0] VS_END = 9'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic       SYNC_ACT = (SYNC_POL != 0);

    logic [9:0] cnt_x, x_nxt;
    logic [8:0] cnt_y, y_nxt;
    logic [7:0] frm_cnt;
    logic       disp, h_sync, v_sync, line_stb, frame_stb;
    logic       x_wrap, y_wrap, frame_wrap;

    always_comb begin
        x_wrap     = (cnt_x == X_LAST);
        y_wrap     = (cnt_y == Y_LAST);
        frame_wrap = vif.pix_ce & x_wrap & y_wrap;
        x_nxt      = cnt_x;
        y_nxt      = cnt_y;
        if (vif.pix_ce) begin
            x_nxt = x_wrap ? 10'd0 : cnt_x + 10'd1;
            if (x_wrap) begin
                y_nxt = y_wrap ? 9'd0 : cnt_y + 9'd1;
            end
        end
    end

    // Decodes use the next-state counters so they land in the same cycle as the counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_x     <= X_LAST;
            cnt_y     <= Y_LAST;
            disp      <= 1'b0;
            h_sync    <= ~SYNC_ACT;
            v_sync    <= ~SYNC_ACT;
            line_stb  <= 1'b0;
            frame_stb <= 1'b0;
            frm_cnt   <= 8'd0;
        end else begin
            cnt_x     <= x_nxt;
            cnt_y     <= y_nxt;
            disp      <= (x_nxt < X_ACT) && (y_nxt < Y_ACT);
            h_sync    <= (x_nxt >= HS_BEG && x_nxt < HS_END) ? SYNC_ACT : ~SYNC_ACT;
            v_sync    <= (y_nxt >= VS_BEG && y_nxt < VS_END) ? SYNC_ACT : ~SYNC_ACT;
            line_stb  <= vif.pix_ce & x_wrap;
            frame_stb <= frame_wrap;
            if (frame_wrap) begin
                frm_cnt <= frm_cnt + 8'd1;
            end
        end
    end

    assign vif.CounterX      = cnt_x;
    assign vif.CounterY      = cnt_y;
    assign vif.inDisplayArea = disp;
    assign vif.vga_h_sync    = h_sync;
    assign vif.vga_v_sync    = v_sync;
    assign vif.line_start    = line_stb;
    assign vif.frame_start   = frame_stb;
    assign vif.frame_count   = frm_cnt;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size VGA instance plus two small-geometry instances (both sync polarities).
// The reference derives every output from the count of pix_ce edges since reset.
module tb_vga_timing_gen;
    logic clk;
    logic rst_n;
    logic ce;

    int checks   = 0;
    int failures = 0;
    int mdl_n;
    bit mdl_ce;

    vga_timing_if if_big ();
    vga_timing_if if_sm ();
    vga_timing_if if_pos ();

    assign if_big.pix_ce = ce;
    assign if_sm.pix_ce  = ce;
    assign if_pos.pix_ce = ce;

    vga_timing_gen u_big (.clk(clk), .rst_n(rst_n), .vif(if_big));

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_POL(0)
    ) u_sm (.clk(clk), .rst_n(rst_n), .vif(if_sm));

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_POL(1)
    ) u_pos (.clk(clk), .rst_n(rst_n), .vif(if_pos));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference state: pix_ce edges seen since reset and whether the latest edge had pix_ce.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_n  <= 0;
            mdl_ce <= 1'b0;
        end else begin
            mdl_ce <= ce;
            if (ce) mdl_n <= mdl_n + 1;
        end
    end

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_dut(input string tag,
                             input int ha, input int hf, input int hs, input int hb,
                             input int va, input int vf, input int vs, input int vb,
                             input bit pol,
                             input int ax, input int ay, input int afc,
                             input bit ad, input bit ah, input bit av,
                             input bit als, input bit afs);
        int ht, vt, ex, ey, efc, idx;
        bit ed, eh, ev, els, efs;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        if (mdl_n == 0) begin
            ex  = ht - 1;
            ey  = vt - 1;
            efc = 0;
        end else begin
            idx = (mdl_n - 1) % (ht * vt);
            ex  = idx % ht;
            ey  = idx / ht;
            efc = ((mdl_n - 1) / (ht * vt) + 1) % 256;
        end
        ed  = (ex < ha) && (ey < va);
        eh  = (ex >= ha + hf && ex < ha + hf + hs) ? pol : !pol;
        ev  = (ey >= va + vf && ey < va + vf + vs) ? pol : !pol;
        els = mdl_ce && mdl_n > 0 && ex == 0;
        efs = els && ey == 0;
        cmp({tag, "_x"}, ax, ex);
        cmp({tag, "_y"}, ay, ey);
        cmp({tag, "_fc"}, afc, efc);
        cmp({tag, "_disp"}, int'(ad), int'(ed));
        cmp({tag, "_hsync"}, int'(ah), int'(eh));
        cmp({tag, "_vsync"}, int'(av), int'(ev));
        cmp({tag, "_line_start"}, int'(als), int'(els));
        cmp({tag, "_frame_start"}, int'(afs), int'(efs));
    endtask

    always @(negedge clk) begin
        check_dut("big", 640, 16, 96, 48, 480, 10, 2, 20, 1'b0,
                  int'(if_big.CounterX), int'(if_big.CounterY), int'(if_big.frame_count),
                  if_big.inDisplayArea, if_big.vga_h_sync, if_big.vga_v_sync,
                  if_big.line_start, if_big.frame_start);
        check_dut("sm", 8, 2, 3, 2, 6, 1, 2, 1, 1'b0,
                  int'(if_sm.CounterX), int'(if_sm.CounterY), int'(if_sm.frame_count),
                  if_sm.inDisplayArea, if_sm.vga_h_sync, if_sm.vga_v_sync,
                  if_sm.line_start, if_sm.frame_start);
        check_dut("pos", 8, 2, 3, 2, 6, 1, 2, 1, 1'b1,
                  int'(if_pos.CounterX), int'(if_pos.CounterY), int'(if_pos.frame_count),
                  if_pos.inDisplayArea, if_pos.vga_h_sync, if_pos.vga_v_sync,
                  if_pos.line_start, if_pos.frame_start);
    end

    initial begin
        int hs_cnt, hs_first, hs_last, disp_fall, ls_extra;
        bit disp_prev;
        int vmin, vmax, pvmin, pvmax, phmin, phmax, disp_bad, fs_cnt;
        int fs_at[2];
        int fc_at[2];
        int ls_cnt, hold_bad, stb_bad, prev_x;
        int ls_at[2];
        bit ce_prev, found;

        ce    = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        cmp("rst_x", int'(if_big.CounterX), 799);
        cmp("rst_y", int'(if_big.CounterY), 511);
        cmp("rst_fc", int'(if_big.frame_count), 0);
        cmp("rst_hsync", int'(if_big.vga_h_sync), 1);

        // First pix_ce after release lands on (0,0) with both strobes.
        rst_n = 1'b1;
        ce    = 1'b1;
        @(posedge clk);
        #2;
        cmp("t1_x", int'(if_big.CounterX), 0);
        cmp("t1_y", int'(if_big.CounterY), 0);
        cmp("t1_disp", int'(if_big.inDisplayArea), 1);
        cmp("t1_line_start", int'(if_big.line_start), 1);
        cmp("t1_frame_start", int'(if_big.frame_start), 1);
        cmp("t1_fc", int'(if_big.frame_count), 1);

        // One full line of the 640x480 raster.
        hs_cnt = 0; hs_first = -1; hs_last = -1; disp_fall = -1; ls_extra = 0;
        disp_prev = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if (!if_big.vga_h_sync) begin
                if (hs_first < 0) hs_first = int'(if_big.CounterX);
                hs_last = int'(if_big.CounterX);
                hs_cnt++;
            end
            if (disp_prev && !if_big.inDisplayArea && disp_fall < 0)
                disp_fall = int'(if_big.CounterX);
            disp_prev = if_big.inDisplayArea;
            if (i > 0 && if_big.line_start) ls_extra++;
            @(posedge clk);
            #2;
        end
        cmp("t2_hsync_width", hs_cnt, 96);
        cmp("t2_hsync_first", hs_first, 656);
        cmp("t2_hsync_last", hs_last, 751);
        cmp("t2_disp_fall_x", disp_fall, 640);
        cmp("t2_ls_inside_line", ls_extra, 0);
        cmp("t2_ls_at_800", int'(if_big.line_start), 1);
        cmp("t2_y_after_line", int'(if_big.CounterY), 1);

        // 801 pix_ce edges into the 15x10 raster: pixel 800 mod 150 = 50 -> (5,3), frame 6.
        cmp("t3_sm_x", int'(if_sm.CounterX), 5);
        cmp("t3_sm_y", int'(if_sm.CounterY), 3);
        cmp("t3_sm_fc", int'(if_sm.frame_count), 6);

        vmin = 999; vmax = -1; pvmin = 999; pvmax = -1; phmin = 999; phmax = -1;
        disp_bad = 0; fs_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            if (!if_sm.vga_v_sync) begin
                if (int'(if_sm.CounterY) < vmin) vmin = int'(if_sm.CounterY);
                if (int'(if_sm.CounterY) > vmax) vmax = int'(if_sm.CounterY);
            end
            if (if_pos.vga_v_sync) begin
                if (int'(if_pos.CounterY) < pvmin) pvmin = int'(if_pos.CounterY);
                if (int'(if_pos.CounterY) > pvmax) pvmax = int'(if_pos.CounterY);
            end
            if (if_pos.vga_h_sync) begin
                if (int'(if_pos.CounterX) < phmin) phmin = int'(if_pos.CounterX);
                if (int'(if_pos.CounterX) > phmax) phmax = int'(if_pos.CounterX);
            end
            if (if_sm.inDisplayArea && if_sm.CounterY >= 9'd6) disp_bad++;
            if (if_sm.frame_start) begin
                if (fs_cnt < 2) begin
                    fs_at[fs_cnt] = i;
                    fc_at[fs_cnt] = int'(if_sm.frame_count);
                end
                fs_cnt++;
            end
            @(posedge clk);
            #2;
        end
        cmp("t3_vsync_first_line", vmin, 7);
        cmp("t3_vsync_last_line", vmax, 8);
        cmp("t3_disp_below_active", disp_bad, 0);
        cmp("t3_frame_starts", fs_cnt, 2);
        cmp("t3_first_fs_cycle", fs_at[0], 100);
        cmp("t3_frame_period", fs_at[1] - fs_at[0], 150);
        cmp("t3_fc_first", fc_at[0], 7);
        cmp("t3_fc_second", fc_at[1], 8);
        cmp("t6_vsync_hi_first", pvmin, 7);
        cmp("t6_vsync_hi_last", pvmax, 8);
        cmp("t6_hsync_hi_first", phmin, 10);
        cmp("t6_hsync_hi_last", phmax, 12);

        // Half-rate pixel enable doubles the line period and gates the strobes.
        ls_cnt = 0; hold_bad = 0; stb_bad = 0;
        for (int i = 0; i < 3400; i++) begin
            prev_x  = int'(if_big.CounterX);
            ce      = (i % 2 == 0);
            ce_prev = ce;
            @(posedge clk);
            #2;
            if (!ce_prev) begin
                if (int'(if_big.CounterX) != prev_x) hold_bad++;
                if (if_big.line_start || if_big.frame_start) stb_bad++;
            end
            if (if_big.line_start) begin
                if (ls_cnt < 2) ls_at[ls_cnt] = i;
                ls_cnt++;
            end
        end
        cmp("t4_line_starts", ls_cnt, 2);
        cmp("t4_line_period", ls_at[1] - ls_at[0], 1600);
        cmp("t4_hold_on_ce0", hold_bad, 0);
        cmp("t4_strobe_on_ce0", stb_bad, 0);

        // Asynchronous reset mid-line, checked before any further clock edge.
        ce    = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(posedge clk);
            #2;
            if (if_big.CounterX == 10'd300) found = 1'b1;
        end
        cmp("t5_reached_x300", int'(found), 1);
        rst_n = 1'b0;
        #1;
        cmp("t5_x", int'(if_big.CounterX), 799);
        cmp("t5_y", int'(if_big.CounterY), 511);
        cmp("t5_fc", int'(if_big.frame_count), 0);
        cmp("t5_hsync", int'(if_big.vga_h_sync), 1);
        cmp("t5_vsync", int'(if_big.vga_v_sync), 1);
        cmp("t5_disp", int'(if_big.inDisplayArea), 0);
        cmp("t5_line_start", int'(if_big.line_start), 0);
        cmp("t5_pos_vsync", int'(if_pos.vga_v_sync), 0);

        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        cmp("t5_restart_x", int'(if_big.CounterX), 0);
        cmp("t5_restart_fs", int'(if_big.frame_start), 1);
        cmp("t5_restart_fc", int'(if_big.frame_count), 1);
        repeat (200) @(posedge clk);
        #2;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
